fixed_act_lut_ctrl: RTL
=======================

Name: fixed_act_lut_ctrl

Overview:
Controller for a shared activation lookup table (ELU/GELU-style map) in the activations library. It runs a load phase that streams all LUT entries into an internal RAM, then shares that single-read-port table among NUM_LANES requesters through round-robin arbitration. Each result is returned on one output stream tagged with the requesting lane. It sits between parallel activation lanes and the LUT storage.

Parameters:
DATA_IN_0_PRECISION_0, 8, width of the lookup index (input activation code).
DATA_OUT_0_PRECISION_0, 8, width of each LUT entry and each result.
NUM_LANES, 4, number of requesters sharing the table; minimum 1.
LUT_DEPTH (localparam), 2**DATA_IN_0_PRECISION_0, number of entries.
LANE_W (localparam), max(1,$clog2(NUM_LANES)), width of the lane tag.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
cfg_start  in  1  one-cycle pulse that requests a (re)load of the table.
cfg_wr_data  in  DATA_OUT_0_PRECISION_0  next LUT entry, sent in address order.
cfg_wr_valid  in  1  cfg_wr_data is valid.
cfg_wr_ready  out  1  high only in LOAD.
cfg_done  out  1  one-cycle pulse after the last entry is written.
lut_loaded  out  1  table is valid and lookups are enabled.
data_in_0  in  NUM_LANES x DATA_IN_0_PRECISION_0  unpacked array; lookup index per lane.
data_in_0_valid  in  NUM_LANES  per-lane request valid.
data_in_0_ready  out  NUM_LANES  per-lane grant; one-hot or zero.
data_out_0  out  DATA_OUT_0_PRECISION_0  LUT result.
data_out_0_lane  out  LANE_W  lane that issued the result.
data_out_0_valid  out  1  result valid.
data_out_0_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst=0, asynchronous): state=UNLOADED, write address=0, RR pointer=0. All outputs are 0: cfg_wr_ready, cfg_done, lut_loaded, data_in_0_ready, data_out_0, data_out_0_lane, data_out_0_valid. RAM contents are not cleared, but lut_loaded=0 invalidates them.
- FSM states: UNLOADED, LOAD, RUN, DRAIN.
- UNLOADED: on cfg_start, go to LOAD and set address=0.
- LOAD: cfg_wr_ready=1. Each beat with cfg_wr_valid and cfg_wr_ready high writes RAM[addr] and increments addr. The beat written at addr=LUT_DEPTH-1 moves the FSM to RUN, pulses cfg_done next cycle and sets lut_loaded=1. cfg_start during LOAD is ignored and the load does not restart.
- RUN:
  - Issue condition: out_free = !data_out_0_valid || data_out_0_ready.
  - When out_free, the arbiter grants the first valid lane at or after the RR pointer, wrapping modulo NUM_LANES.
  - data_in_0_ready is combinational: high for the granted lane only, and only when out_free.
  - On a grant, the RR pointer moves to grant+1, wrapping modulo NUM_LANES. With no valid lanes, the pointer holds.
  - The RAM read is synchronous. Result and lane tag appear with data_out_0_valid one cycle after the grant.
  - With continuous downstream ready, throughput is one lookup per cycle.
  - While data_out_0_valid=1 and data_out_0_ready=0, data_out_0 and data_out_0_lane hold stable and no grants are issued.
- cfg_start in RUN:
  - lut_loaded drops to 0 the next cycle and grants stop immediately, including in the cfg_start cycle.
  - FSM goes to DRAIN and stays there until data_out_0_valid=0, i.e. the in-flight result has been accepted. It then goes to LOAD.
- cfg_start in DRAIN is ignored.
- Simultaneous cfg_start and last load beat: the beat completes, FSM goes to RUN, cfg_start is dropped.
- Index width equals the address width, so there is no range check; every index maps to a valid entry.

Optional Feature:
Macro ACT_LUT_CNT_EN.
- Defined: adds output lookup_count [31:0], a count of accepted results (data_out_0_valid && data_out_0_ready).
  - Saturates at 32'hFFFFFFFF.
  - Clears on reset and when LOAD is entered.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package act_lut_pkg holds:
  - typedef enum logic [1:0] act_lut_state_t {UNLOADED, LOAD, RUN, DRAIN};
  - function clog2_min1 used to compute LANE_W.
- Sub-module act_lut_rr_arbiter (parameter NUM_LANES) contains:
  - inputs: request vector, enable, pointer;
  - outputs: one-hot grant and encoded grant index.
- The RAM is an inferred array inside the top module.

Test Plan:
- Reset then lookup: hold data_in_0_valid=4'b1111 with no load -> data_in_0_ready=0 and lut_loaded=0 indefinitely. Assert rst mid-LOAD after 100 beats -> UNLOADED, cfg_wr_ready=0.
- Load LUT[i]=255-i over 256 beats, with random 30% cfg_wr_valid gaps -> cfg_done pulses once after beat 255 and lut_loaded=1.
- Lane 2 alone requests index 8'h10 -> granted in the same cycle; one cycle later data_out_0=8'hEF, data_out_0_lane=2.
- All 4 lanes requesting continuously with ready=1 -> grants cycle 0,1,2,3,0. One result per cycle, each equal to 255-index.
- Hold data_out_0_ready=0 for 5 cycles with a result pending -> data_out_0 and data_out_0_lane stay stable and data_in_0_ready=0. On release, the next grant goes to the next lane in RR order.
- Pulse cfg_start while a result is stalled -> state DRAIN and no grants. After acceptance, LOAD a new table LUT[i]=i. Then index 8'h10 returns 8'h10; with ACT_LUT_CNT_EN, lookup_count restarts from 0.

Source files
------------

// File: rtl/act_lut_pkg.sv
// Shared types and helpers for the activation LUT controller.
package act_lut_pkg;

  typedef enum logic [1:0] {
    UNLOADED = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } act_lut_state_t;

  // Lane tags need at least one bit even when there is a single lane.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/act_lut_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or after ptr_i,
// wrapping modulo NUM_LANES. Grant is one-hot, or zero when disabled/idle.
module act_lut_rr_arbiter
  import act_lut_pkg::*;
#(
  parameter int NUM_LANES = 4,
  localparam int LANE_W = clog2_min1(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic                 en_i,
  input  logic [LANE_W-1:0]    ptr_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [LANE_W-1:0]    gnt_idx_o
);

  logic              found;
  logic [LANE_W-1:0] cand;

  // Scan lanes starting at the pointer; the first requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = LANE_W'((int'(ptr_i) + i) % NUM_LANES);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fixed_act_lut_ctrl.sv
// Shared activation LUT controller: loads the table, then serves lookups
// from NUM_LANES requesters through a round-robin arbiter.
// Optional feature macro: ACT_LUT_CNT_EN adds lookup_count (accepted results).
//
// state    | meaning
// UNLOADED | table invalid, waiting for cfg_start
// LOAD     | streaming entries into the RAM in address order
// RUN      | table valid, lookups granted
// DRAIN    | reload requested, waiting for the in-flight result to leave
module fixed_act_lut_ctrl
  import act_lut_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 8,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int NUM_LANES              = 4,
  localparam int LUT_DEPTH = 2 ** DATA_IN_0_PRECISION_0,
  localparam int LANE_W    = clog2_min1(NUM_LANES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] cfg_wr_data,
  input  logic                              cfg_wr_valid,
  output logic                              cfg_wr_ready,
  output logic                              cfg_done,
  output logic                              lut_loaded,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [NUM_LANES],
  input  logic [NUM_LANES-1:0]              data_in_0_valid,
  output logic [NUM_LANES-1:0]              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic [LANE_W-1:0]                 data_out_0_lane,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
`ifdef ACT_LUT_CNT_EN
  ,
  output logic [31:0]                       lookup_count
`endif
);

  localparam int DIN_W  = DATA_IN_0_PRECISION_0;
  localparam int DOUT_W = DATA_OUT_0_PRECISION_0;

  logic [DOUT_W-1:0] ram_q [LUT_DEPTH];

  act_lut_state_t    state_q, state_d;
  logic [DIN_W-1:0]  addr_q, addr_d;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              cfg_done_q, cfg_done_d;
  logic              out_valid_q, out_valid_d;
  logic [DOUT_W-1:0] out_data_q;
  logic [LANE_W-1:0] out_lane_q;

  logic                 out_free;
  logic                 arb_en;
  logic                 wr_beat;
  logic                 last_beat;
  logic [NUM_LANES-1:0] gnt;
  logic [LANE_W-1:0]    gnt_idx;
  logic                 gnt_any;

  // A reload request blocks grants in the very cycle it arrives.
  assign out_free  = !out_valid_q || data_out_0_ready;
  assign arb_en    = (state_q == RUN) && !cfg_start && out_free;
  assign gnt_any   = |gnt;
  assign wr_beat   = (state_q == LOAD) && cfg_wr_valid;
  assign last_beat = wr_beat && (addr_q == {DIN_W{1'b1}});

  act_lut_rr_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arb (
    .req_i    (data_in_0_valid),
    .en_i     (arb_en),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  // Next-state logic for the FSM, write address, RR pointer and output valid.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cfg_done_d  = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      UNLOADED: begin
        if (cfg_start) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      LOAD: begin
        if (wr_beat) begin
          addr_d = addr_q + 1'b1;
          if (last_beat) begin
            state_d    = RUN;
            cfg_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cfg_start) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid_q) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      default: state_d = UNLOADED;
    endcase
    if (gnt_any) begin
      out_valid_d = 1'b1;
      rr_ptr_d    = LANE_W'((int'(gnt_idx) + 1) % NUM_LANES);
    end else if (data_out_0_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control registers and the registered lookup result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOADED;
      addr_q      <= '0;
      rr_ptr_q    <= '0;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rr_ptr_q    <= rr_ptr_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      if (gnt_any) begin
        out_data_q <= ram_q[data_in_0[gnt_idx]];
        out_lane_q <= gnt_idx;
      end
    end
  end

  // Table storage; contents survive reset and are qualified by lut_loaded.
  always_ff @(posedge clk) begin
    if (wr_beat) ram_q[addr_q] <= cfg_wr_data;
  end

`ifdef ACT_LUT_CNT_EN
  logic [31:0] cnt_q;

  // Saturating count of accepted results, restarted on every new load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q != LOAD && state_d == LOAD) begin
      cnt_q <= '0;
    end else if (out_valid_q && data_out_0_ready && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign lookup_count = cnt_q;
`endif

  assign cfg_wr_ready     = (state_q == LOAD);
  assign cfg_done         = cfg_done_q;
  assign lut_loaded       = (state_q == RUN);
  assign data_in_0_ready  = gnt;
  assign data_out_0       = out_data_q;
  assign data_out_0_lane  = out_lane_q;
  assign data_out_0_valid = out_valid_q;

endmodule
